// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared FSM encoding and protocol constants for the SRAM FIFO
package sram_fifo_pkg;

    localparam int DEFAULT_ADDR_W = 18;

    // Frame sync and command codes shared with the SPI slave controller
    localparam logic [15:0] FRAME_SYNC  = 16'h2DD4;
    localparam logic [7:0]  CMD_CONFIG  = 8'h11;
    localparam logic [7:0]  CMD_DATA_TX = 8'h66;
    localparam logic [7:0]  CMD_DATA_RX = 8'h77;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_SETUP = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_WR_HOLD  = 3'd3,
        ST_RD_ADDR  = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/sram_strobe_timer.sv
// rtl/sram_strobe_timer.sv - wait-state down-counter flagging the last strobe cycle
module sram_strobe_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_last
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - circular word FIFO on external async SRAM with req/hint handshake
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [15:0]       wr_data,
    output logic [15:0]       rd_data,
    output logic              hint,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_wptr, r_rptr, r_addr;
    logic [ADDR_W:0]   r_count;
    logic [15:0]       r_rd_data;
    logic              r_prio_wr, r_op_wr, r_flush_pend, r_hint;
    logic              r_ce_n, r_we_n, r_oe_n, r_dq_oe;
    logic              w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
    logic              w_timer_load, w_timer_last;

    sram_strobe_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_timer_load),
        .o_last  (w_timer_last)
    );

    assign full      = (r_count == DEPTH);
    assign empty     = (r_count == '0);
    assign w_wr_elig = wr_req && !full;
    assign w_rd_elig = rd_req && !empty;

    // Flush in IDLE wins over any request; on a tie the side not served last wins
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (!flush) begin
            if (w_wr_elig && w_rd_elig) begin
                w_grant_wr = r_prio_wr;
                w_grant_rd = !r_prio_wr;
            end else begin
                w_grant_wr = w_wr_elig;
                w_grant_rd = w_rd_elig;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_wr)      w_state_next = ST_WR_SETUP;
                else if (w_grant_rd) w_state_next = ST_RD_ADDR;
            end
            ST_WR_SETUP: begin
                w_state_next = ST_WR_PULSE;
                w_timer_load = 1'b1;
            end
            ST_WR_PULSE: if (w_timer_last) w_state_next = ST_WR_HOLD;
            ST_WR_HOLD:  w_state_next = ST_DONE;
            ST_RD_ADDR: begin
                w_state_next = ST_RD_WAIT;
                w_timer_load = 1'b1;
            end
            ST_RD_WAIT:  if (w_timer_last) w_state_next = ST_DONE;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they stay glitch-free and state-aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ce_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_dq_oe   <= 1'b0;
            r_hint    <= 1'b0;
            r_addr    <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_ce_n  <= !(w_state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD,
                                              ST_RD_ADDR, ST_RD_WAIT});
            r_we_n  <= (w_state_next != ST_WR_PULSE);
            r_oe_n  <= !(w_state_next inside {ST_RD_ADDR, ST_RD_WAIT});
            r_dq_oe <= (w_state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
            r_hint  <= (w_state_next == ST_DONE);
            if (r_state == ST_IDLE && w_grant_wr)      r_addr <= r_wptr;
            else if (r_state == ST_IDLE && w_grant_rd) r_addr <= r_rptr;
            if (r_state == ST_RD_WAIT && w_timer_last) r_rd_data <= sram_dq_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_prio_wr    <= 1'b0;
            r_op_wr      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && (w_grant_wr || w_grant_rd)) r_op_wr <= w_grant_wr;
            if (r_state == ST_IDLE && flush) begin
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_count      <= '0;
                r_flush_pend <= 1'b0;
            end else if (r_state == ST_DONE) begin
                // A flush raised mid-access discards the pointer update of that access
                if (r_flush_pend || flush) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else if (r_op_wr) begin
                    r_wptr  <= r_wptr + PTR_ONE;
                    r_count <= r_count + CNT_ONE;
                end else begin
                    r_rptr  <= r_rptr + PTR_ONE;
                    r_count <= r_count - CNT_ONE;
                end
                r_flush_pend <= 1'b0;
                r_prio_wr    <= !r_op_wr;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign count      = r_count;
    assign rd_data    = r_rd_data;
    assign hint       = r_hint;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_oe ? wr_data : 16'h0000;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_we_n  = r_we_n;
    assign sram_oe_n  = r_oe_n;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl with an async SRAM model
module tb_sram_fifo_ctrl;

    localparam int AW = 3;
    localparam int AC = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0;
    logic [15:0]   wr_data = 16'h0000;
    logic [15:0]   rd_data, sram_dq_o, sram_dq_i;
    logic          done_pulse, full, empty, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
    logic [AW:0]   count;
    logic [AW-1:0] sram_addr;

    logic [15:0]   mem [8];
    logic [15:0]   sb[$];
    logic [AW-1:0] m_wptr = '0, m_rptr = '0;
    int            n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req),
        .wr_data(wr_data), .rd_data(rd_data), .hint(done_pulse), .flush(flush),
        .full(full), .empty(empty), .count(count), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

    task automatic do_access(input bit is_wr, input logic [15:0] data, output int lat,
                             output logic [15:0] rdata, output logic [AW-1:0] addr, output bit to);
        lat = 0; to = 1'b1; addr = '0;
        if (is_wr) begin wr_data = data; wr_req = 1'b1; end
        else rd_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!sram_we_n || !sram_oe_n) addr = sram_addr;
            if (done_pulse) begin lat = i; to = 1'b0; break; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        rdata = rd_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        n_checks++; if ({sram_ce_n, sram_we_n, sram_oe_n} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got %b want 111", {sram_ce_n, sram_we_n, sram_oe_n}); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe: got %b want 0", sram_dq_oe); end
        n_checks++; if ({sram_addr, sram_dq_o, rd_data} !== '0) begin n_fail++; $display("FAIL reset_data: addr %h dq_o %h rd_data %h want all 0", sram_addr, sram_dq_o, rd_data); end
        n_checks++; if ({done_pulse, full, empty, count} !== {3'b001, 4'd0}) begin n_fail++; $display("FAIL reset_flags: hint %b full %b empty %b count %0d want 0 0 1 0", done_pulse, full, empty, count); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] rd, exp; logic [AW-1:0] a; bit to;
        logic [15:0] words [3] = '{16'h2DD4, 16'h0305, 16'hAB00};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, words[i], lat, rd, a, to);
            sb.push_back(words[i]); m_wptr = m_wptr + 1'b1;
            n_checks++; if (lat !== AC + 3) begin n_fail++; $display("FAIL basic_wr_latency: got %0d want %0d (to=%0d)", lat, AC + 3, to); end
            n_checks++; if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", count, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, 16'h0, lat, rd, a, to);
            exp = sb.pop_front(); m_rptr = m_rptr + 1'b1;
            n_checks++; if (lat !== AC + 2) begin n_fail++; $display("FAIL basic_rd_latency: got %0d want %0d (to=%0d)", lat, AC + 2, to); end
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL basic_rd_data: got %h want %h", rd, exp); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        int lat, hints; logic [15:0] rd, exp; logic [AW-1:0] a; bit to, got;
        for (int i = 0; i < 8; i++) begin
            do_access(1'b1, 16'(16'h1000 + i), lat, rd, a, to);
            sb.push_back(16'(16'h1000 + i)); m_wptr = m_wptr + 1'b1;
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_fill_timeout: write %0d got no hint", i); end
        end
        n_checks++; if ({full, count} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL full_flags: full %b count %0d want 1 8", full, count); end
        wr_data = 16'hBEEF; wr_req = 1'b1; hints = 0;
        repeat (10) begin @(posedge clk); #1; if (done_pulse) hints++; end
        n_checks++; if (hints !== 0) begin n_fail++; $display("FAIL full_blocked_write: got %0d hints want 0", hints); end
        rd_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(posedge clk); #1; if (done_pulse) got = 1'b1; end
        rd_req = 1'b0;
        exp = sb.pop_front(); m_rptr = m_rptr + 1'b1;
        n_checks++; if (got !== 1'b1 || rd_data !== exp) begin n_fail++; $display("FAIL full_read: hint %b data %h want 1 %h", got, rd_data, exp); end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(posedge clk); #1; if (done_pulse) got = 1'b1; end
        wr_req = 1'b0;
        sb.push_back(16'hBEEF); m_wptr = m_wptr + 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({got, count} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL full_ninth_write: hint %b count %0d want 1 8", got, count); end
        for (int i = 0; i < 8; i++) begin
            do_access(1'b0, 16'h0, lat, rd, a, to);
            exp = sb.pop_front();
            n_checks++; if ({rd, a} !== {exp, m_rptr}) begin n_fail++; $display("FAIL full_drain: data %h addr %0d want %h %0d", rd, a, exp, m_rptr); end
            m_rptr = m_rptr + 1'b1;
        end
    endtask

    task automatic test_wrap();
        int lat; logic [15:0] rd, exp; logic [AW-1:0] a, prev_a; bit to, wrap_seen;
        wrap_seen = 1'b0; prev_a = '0;
        for (int i = 0; i < 20; i++) begin
            do_access(1'b1, 16'(16'h7000 + i * 3), lat, rd, a, to);
            sb.push_back(16'(16'h7000 + i * 3));
            n_checks++; if ({a, count} !== {m_wptr, 4'd1}) begin n_fail++; $display("FAIL wrap_write: addr %0d count %0d want %0d 1", a, count, m_wptr); end
            if (i > 0 && prev_a == 3'd7 && a == 3'd0) wrap_seen = 1'b1;
            prev_a = a; m_wptr = m_wptr + 1'b1;
            do_access(1'b0, 16'h0, lat, rd, a, to);
            exp = sb.pop_front();
            n_checks++; if ({rd, a, count} !== {exp, m_rptr, 4'd0}) begin n_fail++; $display("FAIL wrap_read: data %h addr %0d count %0d want %h %0d 0", rd, a, count, exp, m_rptr); end
            m_rptr = m_rptr + 1'b1;
        end
        n_checks++; if (wrap_seen !== 1'b1) begin n_fail++; $display("FAIL wrap_addr_7_to_0: got %b want 1", wrap_seen); end
    endtask

    task automatic test_back_to_back();
        int lat, grants; logic [15:0] rd, exp; logic [AW-1:0] a; bit to, saw_we, prev_done;
        do_access(1'b1, 16'hA001, lat, rd, a, to); sb.push_back(16'hA001); m_wptr = m_wptr + 1'b1;
        do_access(1'b1, 16'hA002, lat, rd, a, to); sb.push_back(16'hA002); m_wptr = m_wptr + 1'b1;
        wr_data = 16'hC001; wr_req = 1'b1; rd_req = 1'b1;
        grants = 0; saw_we = 1'b0; prev_done = 1'b0;
        for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
            @(posedge clk); #1;
            if (!sram_we_n) saw_we = 1'b1;
            if (done_pulse) begin
                n_checks++; if (prev_done !== 1'b0) begin n_fail++; $display("FAIL arb_hint_width: hint high on consecutive cycles"); end
                n_checks++; if (saw_we !== grants[0]) begin n_fail++; $display("FAIL arb_order: grant %0d was_write %b want %b", grants, saw_we, grants[0]); end
                if (saw_we) begin
                    sb.push_back(wr_data); m_wptr = m_wptr + 1'b1; wr_data = wr_data + 16'h1;
                end else begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF; m_rptr = m_rptr + 1'b1;
                    n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL arb_rd_data: got %h want %h", rd_data, exp); end
                end
                grants++; saw_we = 1'b0;
            end
            prev_done = done_pulse;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({grants, done_pulse, count} !== {32'd4, 1'b0, 4'd2}) begin n_fail++; $display("FAIL arb_summary: grants %0d hint %b count %0d want 4 0 2", grants, done_pulse, count); end
    endtask

    task automatic test_flush();
        int lat; logic [15:0] rd; logic [AW-1:0] a; bit to, in_pulse, got;
        wr_data = 16'h5A5A; wr_req = 1'b1; in_pulse = 1'b0; got = 1'b0;
        for (int i = 0; i < 40 && !in_pulse; i++) begin @(posedge clk); #1; if (!sram_we_n) in_pulse = 1'b1; end
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        if (done_pulse) got = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin @(posedge clk); #1; if (done_pulse) got = 1'b1; end
        wr_req = 1'b0;
        n_checks++; if ({in_pulse, got} !== 2'b11) begin n_fail++; $display("FAIL flush_write_hint: pulse %b hint %b want 1 1", in_pulse, got); end
        @(posedge clk); #1;
        n_checks++; if ({count, empty} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL flush_cleared: count %0d empty %b want 0 1", count, empty); end
        sb.delete(); m_wptr = '0; m_rptr = '0;
        do_access(1'b1, 16'h0F0F, lat, rd, a, to);
        sb.push_back(16'h0F0F); m_wptr = m_wptr + 1'b1;
        n_checks++; if ({to, a, count} !== {1'b0, 3'd0, 4'd1}) begin n_fail++; $display("FAIL flush_next_addr: timeout %b addr %0d count %0d want 0 0 1", to, a, count); end
    endtask

    task automatic test_reset_mid_access();
        int hints; bit in_pulse;
        wr_data = 16'h1234; wr_req = 1'b1; in_pulse = 1'b0;
        for (int i = 0; i < 40 && !in_pulse; i++) begin @(posedge clk); #1; if (!sram_we_n) in_pulse = 1'b1; end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({in_pulse, sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe} !== 5'b11110) begin n_fail++; $display("FAIL rst_mid_strobes: pulse %b we %b ce %b oe %b dq_oe %b want 1 1 1 1 0", in_pulse, sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe); end
        n_checks++; if ({count, done_pulse} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL rst_mid_state: count %0d hint %b want 0 0", count, done_pulse); end
        wr_req = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;
        hints = 0;
        repeat (8) begin @(posedge clk); #1; if (done_pulse) hints++; end
        n_checks++; if ({hints, count, empty} !== {32'd0, 4'd0, 1'b1}) begin n_fail++; $display("FAIL rst_mid_after: hints %0d count %0d empty %b want 0 0 1", hints, count, empty); end
        sb.delete(); m_wptr = '0; m_rptr = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
